// File: rtl/pu4_pkg.sv
// Shared definitions for the PU4 operand loader slice.
// Build option: PU4_LOADER_PAD_EN enables early group termination via in_last.
package pu4_pkg;

  localparam int XLEN      = 5;
  localparam int PU4_LANES = 4;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } pu4_state_e;

  typedef logic [XLEN-1:0] pu4_word_t;

endpackage

// File: rtl/pu4_lane_collector.sv
// Collection register for the PU4 operand loader: gathers words into four
// lanes and flags the word that completes a bundle.
// Build option: PU4_LOADER_PAD_EN lets in_last complete a bundle early,
// zero-filling the lanes that were not written.
module pu4_lane_collector
  import pu4_pkg::*;
#(
  parameter int XLEN = pu4_pkg::XLEN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             accept,
  input  logic [XLEN-1:0]                  in_data,
  input  logic                             in_last,
  output logic                             complete,
  output logic                             comp_last,
  output logic [PU4_LANES-1:0][XLEN-1:0]   comp_lanes,
  output logic                             held_last,
  output logic [PU4_LANES-1:0][XLEN-1:0]   held_lanes
);

  logic [PU4_LANES-1:0][XLEN-1:0] col_r;
  logic [PU4_LANES-1:0][XLEN-1:0] lanes_s;
  logic [1:0]                     idx_r;
  logic                           last_r;
  logic                           complete_s;
  logic                           last_s;

`ifndef PU4_LOADER_PAD_EN
  // in_last has no effect when padding is disabled.
  logic unused_last_s;
  assign unused_last_s = in_last;
`endif

  // Bundle view including this cycle's word, with unwritten lanes zeroed on completion.
  always_comb begin
    lanes_s    = col_r;
    complete_s = 1'b0;
    last_s     = 1'b0;
    if (accept) begin
      lanes_s[idx_r] = in_data;
`ifdef PU4_LOADER_PAD_EN
      complete_s = (idx_r == 2'd3) || in_last;
      last_s     = in_last;
`else
      complete_s = (idx_r == 2'd3);
      last_s     = 1'b0;
`endif
    end else begin
      complete_s = 1'b0;
      last_s     = 1'b0;
    end
    for (int i = 0; i < PU4_LANES; i++) begin
      lanes_s[i] = (complete_s && (i > int'(idx_r))) ? {XLEN{1'b0}} : lanes_s[i];
    end
  end

  // Store accepted words; the completed bundle stays here while the output is busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r  <= {(PU4_LANES*XLEN){1'b0}};
      idx_r  <= 2'd0;
      last_r <= 1'b0;
    end else if (accept) begin
      col_r  <= lanes_s;
      last_r <= last_s;
      idx_r  <= complete_s ? 2'd0 : (idx_r + 2'd1);
    end
  end

  assign complete   = complete_s;
  assign comp_last  = last_s;
  assign comp_lanes = lanes_s;
  assign held_last  = last_r;
  assign held_lanes = col_r;

endmodule

// File: rtl/pu4_operand_loader.sv
// Operand loader for PU4: packs a serial word stream into 4-lane bundles
// with a collection register plus an output register (double buffer).
// Build option: PU4_LOADER_PAD_EN enables in_last padding and out_last.
module pu4_operand_loader
  import pu4_pkg::*;
#(
  parameter int XLEN = pu4_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [XLEN-1:0] num1,
  output logic [XLEN-1:0] num2,
  output logic [XLEN-1:0] num3,
  output logic [XLEN-1:0] num4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last
);

  pu4_state_e                     state_r;
  pu4_state_e                     state_nxt_s;
  logic [PU4_LANES-1:0][XLEN-1:0] out_r;
  logic                           out_valid_r;
  logic                           out_last_r;
  logic                           valid_nxt_s;
  logic                           load_s;
  logic                           load_held_s;
  logic                           in_ready_s;
  logic                           accept_s;
  logic                           xfer_s;
  logic                           slot_free_s;
  logic                           complete_s;
  logic                           comp_last_s;
  logic                           held_last_s;
  logic [PU4_LANES-1:0][XLEN-1:0] comp_lanes_s;
  logic [PU4_LANES-1:0][XLEN-1:0] held_lanes_s;

  assign in_ready_s  = (state_r == FILL);
  assign accept_s    = in_valid & in_ready_s;
  assign xfer_s      = out_valid_r & out_ready;
  assign slot_free_s = ~out_valid_r | xfer_s;

  pu4_lane_collector #(
    .XLEN(XLEN)
  ) u_collector (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept_s),
    .in_data    (in_data),
    .in_last    (in_last),
    .complete   (complete_s),
    .comp_last  (comp_last_s),
    .comp_lanes (comp_lanes_s),
    .held_last  (held_last_s),
    .held_lanes (held_lanes_s)
  );

  // Next state and output-register load decisions.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = out_valid_r & ~xfer_s;
    load_s      = 1'b0;
    load_held_s = 1'b0;
    case (state_r)
      FILL: begin
        if (complete_s) begin
          if (slot_free_s) begin
            load_s      = 1'b1;
            valid_nxt_s = 1'b1;
          end else begin
            // Output still stalled: the bundle waits in the collector.
            state_nxt_s = HOLD;
            valid_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      HOLD: begin
        if (xfer_s) begin
          load_s      = 1'b1;
          load_held_s = 1'b1;
          valid_nxt_s = 1'b1;
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = FILL;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State register and output bundle register; lanes only change on a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= FILL;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_r       <= {(PU4_LANES*XLEN){1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= valid_nxt_s;
      if (load_s) begin
        out_r      <= load_held_s ? held_lanes_s : comp_lanes_s;
        out_last_r <= load_held_s ? held_last_s  : comp_last_s;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign num1      = out_r[0];
  assign num2      = out_r[1];
  assign num3      = out_r[2];
  assign num4      = out_r[3];

endmodule

// File: tb/tb_pu4_operand_loader.sv
// Self-checking bench for pu4_operand_loader: table-driven streaming groups,
// scoreboard of expected bundles, and hand-written stall/reset sequences.
// Works with or without PU4_LOADER_PAD_EN defined.
module tb_pu4_operand_loader;
  import pu4_pkg::*;

  localparam int TXLEN = 5;
  localparam int BW    = 4*TXLEN + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [TXLEN-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [TXLEN-1:0] num1, num2, num3, num4;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  typedef struct {
    logic [3:0][TXLEN-1:0] w;
    int                    n;
    logic                  lastw;
    logic [BW-1:0]         exp;
    bit                    emit;
  } vec_t;

  vec_t          tbl[6];
  logic [BW-1:0] sb[$];
  int            errors = 0;
  int            checks = 0;
  logic          acc;
  bit            ir_low;
  bit            stall_seen;
  logic [BW-1:0] held;

  pu4_operand_loader #(.XLEN(TXLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .num4      (num4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] bund(logic [TXLEN-1:0] a, logic [TXLEN-1:0] b,
                                         logic [TXLEN-1:0] c, logic [TXLEN-1:0] d, logic l);
    return {a, b, c, d, l};
  endfunction

  function automatic logic [3:0][TXLEN-1:0] mkw(logic [TXLEN-1:0] a, logic [TXLEN-1:0] b,
                                                logic [TXLEN-1:0] c, logic [TXLEN-1:0] d);
    logic [3:0][TXLEN-1:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Observe outputs at the falling edge: scoreboard pops and stall stability.
  task automatic sample();
    logic [BW-1:0] got;
    logic [BW-1:0] exp;
    got = {num1, num2, num3, num4, out_last};
    acc = in_valid && in_ready;
    if (!in_ready) ir_low = 1'b1;
    if (!rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && out_valid) check("stall_stable", 32'(got), 32'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bundle: got=%0h expected=none", got);
        end else begin
          exp = sb.pop_front();
          check("bundle", 32'(got), 32'(exp));
        end
      end
      stall_seen = out_valid && !out_ready;
      held = got;
    end
  endtask

  task automatic half();
    @(negedge clk);
    sample();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    half();
    rise();
  endtask

  task automatic send(input logic [TXLEN-1:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      step();
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word=%0d got=not_accepted expected=accepted", d);
    end
    in_last = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    ir_low = 1'b0; stall_seen = 1'b0; held = '0;

    tbl[0] = '{mkw(5'd1, 5'd2, 5'd3, 5'd4), 4, 1'b0, bund(5'd1, 5'd2, 5'd3, 5'd4, 1'b0), 1'b1};
    tbl[1] = '{mkw(5'd31, 5'd0, 5'd31, 5'd0), 4, 1'b0, bund(5'd31, 5'd0, 5'd31, 5'd0, 1'b0), 1'b1};
    tbl[2] = '{mkw(5'd5, 5'd6, 5'd7, 5'd8), 4, 1'b0, bund(5'd5, 5'd6, 5'd7, 5'd8, 1'b0), 1'b1};
`ifdef PU4_LOADER_PAD_EN
    tbl[3] = '{mkw(5'd10, 5'd20, 5'd30, 5'd17), 4, 1'b1, bund(5'd10, 5'd20, 5'd30, 5'd17, 1'b1), 1'b1};
    tbl[4] = '{mkw(5'd9, 5'd10, 5'd0, 5'd0), 2, 1'b1, bund(5'd9, 5'd10, 5'd0, 5'd0, 1'b1), 1'b1};
    tbl[5] = '{mkw(5'd11, 5'd12, 5'd13, 5'd14), 4, 1'b0, bund(5'd11, 5'd12, 5'd13, 5'd14, 1'b0), 1'b1};
`else
    tbl[3] = '{mkw(5'd10, 5'd20, 5'd30, 5'd17), 4, 1'b1, bund(5'd10, 5'd20, 5'd30, 5'd17, 1'b0), 1'b1};
    tbl[4] = '{mkw(5'd9, 5'd10, 5'd0, 5'd0), 2, 1'b1, bund(5'd0, 5'd0, 5'd0, 5'd0, 1'b0), 1'b0};
    tbl[5] = '{mkw(5'd11, 5'd12, 5'd0, 5'd0), 2, 1'b0, bund(5'd9, 5'd10, 5'd11, 5'd12, 1'b0), 1'b1};
`endif

    // Reset values while rst is held low.
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_nums", 32'({num1, num2, num3, num4, out_last}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Table-driven groups streamed back-to-back with out_ready held high.
    ir_low = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        send(tbl[k].w[j], (j == tbl[k].n - 1) ? tbl[k].lastw : 1'b0);
      end
      if (tbl[k].emit) sb.push_back(tbl[k].exp);
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("stream_in_ready_high", 32'(ir_low), 32'd0);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Latency: out_valid visible the cycle after the completing word.
    for (int i = 1; i <= 4; i++) send(5'(i), 1'b0);
    sb.push_back(bund(5'd1, 5'd2, 5'd3, 5'd4, 1'b0));
    in_valid = 1'b0;
    half();
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_num4", 32'(num4), 32'd4);
    rise();
    step();
    check("latency_drained", 32'(out_valid), 32'd0);

    // Stall: two bundles collected while the output is blocked.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send(5'(i), 1'b0);
      if (i == 4) sb.push_back(bund(5'd1, 5'd2, 5'd3, 5'd4, 1'b0));
      if (i == 8) sb.push_back(bund(5'd5, 5'd6, 5'd7, 5'd8, 1'b0));
    end
    in_valid = 1'b0;
    half();
    check("hold_in_ready", 32'(in_ready), 32'd0);
    check("hold_out_valid", 32'(out_valid), 32'd1);
    check("hold_num1", 32'(num1), 32'd1);
    rise();
    repeat (3) step();
    out_ready = 1'b1;
    half();
    check("resume_first_valid", 32'(out_valid), 32'd1);
    rise();
    half();
    check("resume_second_valid", 32'(out_valid), 32'd1);
    check("resume_in_ready", 32'(in_ready), 32'd1);
    rise();
    step();
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Reset with one stalled bundle and a partial group pending.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(5'(i), 1'b0);
    send(5'd21, 1'b0);
    send(5'd22, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_nums", 32'({num1, num2, num3, num4, out_last}), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    stall_seen = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send(5'(i), 1'b0);
    sb.push_back(bund(5'd5, 5'd6, 5'd7, 5'd8, 1'b0));
    in_valid = 1'b0;
    repeat (3) step();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
